// File: rtl/writeback_unit_pkg.sv
// Shared constants and types for the register-file writeback path.
package writeback_unit_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int REG_ADDR_WIDTH   = 5;
    localparam int NUM_REGS         = 32;
    localparam int ZERO_REG         = 0;
    localparam int STARVE_CNT_WIDTH = 4;
    localparam int STARVE_CNT_MAX   = 15;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM
    } wb_src_e;

endpackage

// File: rtl/writeback_unit_scoreboard.sv
// Pending-write scoreboard: tracks registers with an outstanding result,
// gates issue on WAW hazards and reports source-operand busy status.
module wb_scoreboard
    import writeback_unit_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic                      wb_accept,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs2,
    input  logic                      register_write,
    input  logic [REG_ADDR_WIDTH-1:0] write_register,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      wb_orphan
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(ZERO_REG);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                orphan_q;
    logic                orphan_d;

    // A register stays busy one extra cycle while its result sits in the output stage.
    function automatic logic reg_busy(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [NUM_REGS-1:0]       pending,
        input logic                      wr_en,
        input logic [REG_ADDR_WIDTH-1:0] wr_idx
    );
        return (rs != ZERO_IDX) && (pending[rs] || (wr_en && (wr_idx == rs)));
    endfunction

    assign issue_ready = !((issue_rd != ZERO_IDX) && pending_q[issue_rd]);
    assign rs1_busy    = reg_busy(query_rs1, pending_q, register_write, write_register);
    assign rs2_busy    = reg_busy(query_rs2, pending_q, register_write, write_register);
    assign wb_orphan   = orphan_q;

    always_comb begin
        pending_d = pending_q;
        orphan_d  = orphan_q;
        if (wb_accept) begin
            pending_d[wb_rd] = 1'b0;
            if ((wb_rd != ZERO_IDX) && !pending_q[wb_rd]) begin
                orphan_d = 1'b1;
            end
        end
        // issue_ready is already low for a same-cycle writeback to this rd, so the clear wins
        if (issue_valid && issue_ready && (issue_rd != ZERO_IDX)) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            orphan_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            orphan_q  <= orphan_d;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port producer: arbitrates ALU and load results,
// registers the write, and keeps the pending-register scoreboard.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      register_write,
    output logic [REG_ADDR_WIDTH-1:0] write_register,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      wb_orphan
);

    localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_THRESH = STARVE_CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_SAT    = STARVE_CNT_WIDTH'(STARVE_CNT_MAX);

    logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q;
    logic [STARVE_CNT_WIDTH-1:0] starve_cnt_d;
    logic                        register_write_q;
    logic                        register_write_d;
    logic [REG_ADDR_WIDTH-1:0]   write_register_q;
    logic [REG_ADDR_WIDTH-1:0]   write_register_d;
    logic [DATA_WIDTH-1:0]       write_data_q;
    logic [DATA_WIDTH-1:0]       write_data_d;

    wb_src_e                     wb_src;
    logic                        alu_priority;
    logic                        wb_accept;
    logic [REG_ADDR_WIDTH-1:0]   wb_rd;
    logic [DATA_WIDTH-1:0]       wb_data;

    // Loads normally win; a starved ALU overrides once its counter reaches the limit.
    always_comb begin
        alu_priority = alu_valid && (starve_cnt_q >= STARVE_THRESH);
        wb_src       = WB_NONE;
        if (alu_priority) begin
            wb_src = WB_ALU;
        end else if (mem_valid) begin
            wb_src = WB_MEM;
        end else if (alu_valid) begin
            wb_src = WB_ALU;
        end
    end

    assign alu_ready = (wb_src == WB_ALU);
    assign mem_ready = (wb_src == WB_MEM);

    always_comb begin
        wb_accept = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        case (wb_src)
            WB_ALU: begin
                wb_accept = 1'b1;
                wb_rd     = alu_rd;
                wb_data   = alu_data;
            end
            WB_MEM: begin
                wb_accept = 1'b1;
                wb_rd     = mem_rd;
                wb_data   = mem_data;
            end
            default: begin
                wb_accept = 1'b0;
            end
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (alu_ready) begin
            starve_cnt_d = '0;
        end else if (alu_valid && (starve_cnt_q != STARVE_SAT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Index and data hold when idle so the last write stays visible downstream.
    always_comb begin
        register_write_d = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (wb_accept) begin
            register_write_d = (wb_rd != REG_ADDR_WIDTH'(ZERO_REG));
            write_register_d = wb_rd;
            write_data_d     = wb_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q     <= '0;
            register_write_q <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            starve_cnt_q     <= starve_cnt_d;
            register_write_q <= register_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    assign register_write = register_write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;

    wb_scoreboard u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_ready    (issue_ready),
        .wb_accept      (wb_accept),
        .wb_rd          (wb_rd),
        .query_rs1      (query_rs1),
        .query_rs2      (query_rs2),
        .register_write (register_write_q),
        .write_register (write_register_q),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .wb_orphan      (wb_orphan)
    );

endmodule
